proto_stream_scheduler: RTL and testbench

Round-robin scheduler that shares one `protoDeserialize` instance between `NUM_SRC` independent protobuf byte-stream sources. It grants one source for a whole message, clears the deserializer before the message starts, and forwards that message's bytes one per cycle. It also reports completion, length and error per message. It sits between the ingress framers and the deserializer's `protoStream_i`/`protoStream_valid_i` inputs.

---
 rtl/proto_stream_scheduler.sv | 155 +++++++++++++++
 tb/tb_proto_stream_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proto_stream_scheduler.sv
// rtl/proto_stream_scheduler.sv - round-robin whole-message scheduler feeding one shared protobuf deserializer
// Optional stall timeout on the granted source: define PROTO_SCHED_TIMEOUT_EN.
module proto_stream_scheduler #(
    parameter int NUM_SRC        = 4,
    parameter int MAX_MSG_LEN    = 255,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NUM_SRC*8-1:0]       src_data_i,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    input  logic [NUM_SRC-1:0]         src_last_i,
    output logic [NUM_SRC-1:0]         src_ready_o,
    output logic [7:0]                 protoStream_o,
    output logic                       protoStream_valid_o,
    output logic                       deser_clr_o,
    output logic [$clog2(NUM_SRC)-1:0] grant_o,
    output logic                       busy_o,
    output logic                       msg_done_o,
    output logic [7:0]                 msg_len_o,
    output logic                       msg_err_o
);

    localparam int GW = $clog2(NUM_SRC);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic          pick_found;
    logic [7:0]    byte_cnt;
    logic [7:0]    cur_data;
    logic          cur_valid;
    logic          cur_last;
    logic          accept;
    logic          at_limit;

`ifdef PROTO_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;
`endif

    // Walk downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        int j;
        pick       = rr_ptr;
        pick_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            if (src_valid_i[j]) begin
                pick       = GW'(j);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        cur_data    = 8'd0;
        cur_valid   = 1'b0;
        cur_last    = 1'b0;
        src_ready_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_o == GW'(k)) begin
                cur_data       = src_data_i[k*8 +: 8];
                cur_valid      = src_valid_i[k];
                cur_last       = src_last_i[k];
                src_ready_o[k] = (state == S_STREAM);
            end
        end
    end

    assign accept   = (state == S_STREAM) && cur_valid;
    assign at_limit = (byte_cnt == 8'(MAX_MSG_LEN - 1));
    assign busy_o   = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state               <= S_IDLE;
            rr_ptr              <= '0;
            grant_o             <= '0;
            byte_cnt            <= 8'd0;
            protoStream_o       <= 8'd0;
            protoStream_valid_o <= 1'b0;
            deser_clr_o         <= 1'b0;
            msg_done_o          <= 1'b0;
            msg_len_o           <= 8'd0;
            msg_err_o           <= 1'b0;
`ifdef PROTO_SCHED_TIMEOUT_EN
            stall_cnt           <= '0;
`endif
        end else begin
            deser_clr_o         <= 1'b0;
            protoStream_valid_o <= 1'b0;
            msg_done_o          <= 1'b0;
            msg_len_o           <= 8'd0;
            msg_err_o           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_o     <= pick;
                        deser_clr_o <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    byte_cnt <= 8'd0;
`ifdef PROTO_SCHED_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        protoStream_o       <= cur_data;
                        protoStream_valid_o <= 1'b1;
                        byte_cnt            <= byte_cnt + 8'd1;
`ifdef PROTO_SCHED_TIMEOUT_EN
                        stall_cnt           <= '0;
`endif
                        // Overflow ends the message here; the rest stays queued at the source.
                        if (cur_last || at_limit) begin
                            msg_done_o <= 1'b1;
                            msg_len_o  <= byte_cnt + 8'd1;
                            msg_err_o  <= !cur_last;
                            state      <= S_DONE;
                        end
                    end
`ifdef PROTO_SCHED_TIMEOUT_EN
                    else if (stall_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        msg_done_o <= 1'b1;
                        msg_len_o  <= byte_cnt;
                        msg_err_o  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        stall_cnt <= stall_cnt + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    rr_ptr <= (grant_o == GW'(NUM_SRC - 1)) ? '0 : grant_o + GW'(1);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proto_stream_scheduler.sv
// tb/tb_proto_stream_scheduler.sv - scoreboard bench for proto_stream_scheduler
module tb_proto_stream_scheduler;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            reset_ni;
    logic [NS*8-1:0] src_data_i;
    logic [NS-1:0]   src_valid_i;
    logic [NS-1:0]   src_last_i;
    logic [NS-1:0]   src_ready_o;
    logic [7:0]      protoStream_o;
    logic            protoStream_valid_o;
    logic            deser_clr_o;
    logic [1:0]      grant_o;
    logic            busy_o;
    logic            msg_done_o;
    logic [7:0]      msg_len_o;
    logic            msg_err_o;

    always #5 clk = ~clk;

    proto_stream_scheduler #(
        .NUM_SRC(NS),
        .MAX_MSG_LEN(255),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk),
        .reset_ni(reset_ni),
        .src_data_i(src_data_i),
        .src_valid_i(src_valid_i),
        .src_last_i(src_last_i),
        .src_ready_o(src_ready_o),
        .protoStream_o(protoStream_o),
        .protoStream_valid_o(protoStream_valid_o),
        .deser_clr_o(deser_clr_o),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .msg_done_o(msg_done_o),
        .msg_len_o(msg_len_o),
        .msg_err_o(msg_err_o)
    );

    // Source entry: bit9 = idle cycle marker, bit8 = last, bits7:0 = data.
    logic [9:0]  srcq[NS][$];
    logic [7:0]  sbq[$];
    logic [12:0] doneq[$];
    int          grant_log[$];
    int          mlen[NS];
    int total = 0, bad = 0;
    int cyc, first_out, last_out, done_cyc, clr_cnt, done_cnt, out_cnt, tout_gap;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int gl(int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic bit srcs_empty();
        for (int k = 0; k < NS; k++) if (srcq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        logic [NS-1:0]   v, l;
        logic [NS*8-1:0] d;
        logic [9:0]      h;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < NS; k++) begin
            if (srcq[k].size() != 0) begin
                h = srcq[k][0];
                if (h[9]) begin
                    void'(srcq[k].pop_front());
                end else begin
                    v[k] = 1'b1;
                    l[k] = h[8];
                    d[k*8 +: 8] = h[7:0];
                    if (src_ready_o[k]) begin
                        void'(srcq[k].pop_front());
                        sbq.push_back(h[7:0]);
                        mlen[k]++;
                        if (h[8]) begin
                            doneq.push_back({4'(k), 8'(mlen[k]), 1'b0});
                            mlen[k] = 0;
                        end else if (mlen[k] == 255) begin
                            doneq.push_back({4'(k), 8'd255, 1'b1});
                            mlen[k] = 0;
                        end
                    end
                end
            end
        end
        src_valid_i = v;
        src_last_i  = l;
        src_data_i  = d;
    endtask

    task automatic observe();
        logic [NS-1:0] onehot;
        logic [12:0]   e;
        cyc++;
        onehot = NS'(1) << grant_o;
        check("ready_legal", (src_ready_o == '0) ||
              (src_ready_o == onehot && !deser_clr_o && !msg_done_o), 1);
        if (deser_clr_o) begin
            clr_cnt++;
            grant_log.push_back(int'(grant_o));
        end
        if (protoStream_valid_o) begin
            out_cnt++;
            if (sbq.size() == 0) check("unexpected_byte", 1, 0);
            else check("byte", protoStream_o, sbq.pop_front());
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (msg_done_o) begin
            done_cnt++;
            done_cyc = cyc;
            if (!protoStream_valid_o) tout_gap = cyc - last_out;
            if (doneq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = doneq.pop_front();
                check("done_grant", grant_o, e[12:9]);
                check("done_len", msg_len_o, e[8:1]);
                check("done_err", msg_err_o, e[0]);
            end
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic run(int maxc);
        int n = 0;
        while (!(srcs_empty() && sbq.size() == 0 && doneq.size() == 0 && !busy_o) && n < maxc) begin
            step();
            n++;
        end
        check("drain_in_budget", n < maxc, 1);
    endtask

    task automatic clear_stats();
        grant_log.delete();
        first_out = -1; last_out = -1; done_cyc = -1; tout_gap = -1;
        clr_cnt = 0; done_cnt = 0; out_cnt = 0; cyc = 0;
    endtask

    task automatic do_reset();
        reset_ni    = 1'b0;
        src_valid_i = '0;
        src_last_i  = '0;
        src_data_i  = '0;
        #1;
        check("reset_outputs", {src_ready_o, protoStream_o, protoStream_valid_o, deser_clr_o,
                                grant_o, busy_o, msg_done_o, msg_len_o, msg_err_o}, 0);
        for (int k = 0; k < NS; k++) begin
            srcq[k].delete();
            mlen[k] = 0;
        end
        sbq.delete();
        doneq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        clear_stats();
    endtask

    task automatic push_msg(int k, int len, int base, bit with_last);
        for (int b = 0; b < len; b++)
            srcq[k].push_back({1'b0, with_last && (b == len - 1), 8'(base + b)});
    endtask

    task automatic push_idle(int k, int n);
        for (int b = 0; b < n; b++) srcq[k].push_back(10'h200);
    endtask

    initial begin
        logic [7:0] t1 [5];
        int seen;
        t1 = '{8'h08, 8'h96, 8'h01, 8'h10, 8'h02};
        reset_ni = 1'b1;
        src_valid_i = '0; src_last_i = '0; src_data_i = '0;
        #2;
        do_reset();

        // single 5-byte message from source 0
        for (int b = 0; b < 5; b++) srcq[0].push_back({1'b0, b == 4, t1[b]});
        run(100);
        check("t1_clr_pulses", clr_cnt, 1);
        check("t1_first_byte_cycle", first_out, 3);
        check("t1_done_cycle", done_cyc, 7);
        check("t1_out_bytes", out_cnt, 5);

        // three continuous requesters, two 2-byte messages each
        do_reset();
        foreach (t1[i]) ;
        for (int m = 0; m < 2; m++) begin
            push_msg(0, 2, 8'h00 + m * 2, 1);
            push_msg(1, 2, 8'h10 + m * 2, 1);
            push_msg(3, 2, 8'h30 + m * 2, 1);
        end
        run(200);
        check("t2_grants", grant_log.size(), 6);
        check("t2_g0", gl(0), 0);
        check("t2_g1", gl(1), 1);
        check("t2_g2", gl(2), 3);
        check("t2_g3", gl(3), 0);
        check("t2_g4", gl(4), 1);
        check("t2_g5", gl(5), 3);

        // 300 bytes from source 2: overflow at 255, remainder of 45 bytes
        clear_stats();
        push_msg(2, 300, 0, 1);
        run(1000);
        check("t3_dones", done_cnt, 2);
        check("t3_out_bytes", out_cnt, 300);
        check("t3_grant_a", gl(0), 2);
        check("t3_grant_b", gl(1), 2);

        // granted source stalls 10 cycles mid-message
        clear_stats();
        push_msg(0, 3, 8'h40, 0);
        push_idle(0, 10);
        push_msg(0, 2, 8'h43, 1);
        push_msg(1, 1, 8'h51, 1);
        push_msg(2, 1, 8'h62, 1);
        run(200);
        check("t4_dones", done_cnt, 3);
        check("t4_out_bytes", out_cnt, 7);
        check("t4_g0", gl(0), 0);
        check("t4_g1", gl(1), 1);
        check("t4_g2", gl(2), 2);

`ifdef PROTO_SCHED_TIMEOUT_EN
        // stalled source is cut off after the timeout
        do_reset();
        push_msg(1, 3, 8'h70, 0);
        push_idle(1, 80);
        push_msg(3, 2, 8'h80, 1);
        doneq.push_back({4'd1, 8'd3, 1'b1});
        run(400);
        check("t5_timeout_gap", tout_gap, 64);
        check("t5_g0", gl(0), 1);
        check("t5_g1", gl(1), 3);
`endif

        // reset while streaming, then arbitration restarts at source 0
        clear_stats();
        push_msg(1, 6, 8'h90, 1);
        seen = 0;
        while (out_cnt < 2 && seen < 30) begin
            step();
            seen++;
        end
        check("t6_two_bytes_out", out_cnt, 2);
        do_reset();
        check("t6_no_done", done_cnt, 0);
        push_msg(1, 1, 8'hA1, 1);
        push_msg(0, 1, 8'hA0, 1);
        run(100);
        check("t6_g0", gl(0), 0);
        check("t6_g1", gl(1), 1);
        check("t6_dones", done_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
